// File: rtl/ahb2apb_nport_pkg.sv
// Shared encodings for the AHB-Lite to multi-port APB bridge: AHB transfer
// codes, bridge FSM states and the byte-strobe helper.
package ahb2apb_nport_pkg;

  localparam int MAX_NSLV = 8;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_ERR1   = 3'd3,
    ST_ERR2   = 3'd4
  } state_e;

  function automatic logic [3:0] strb_for(input logic [2:0] size, input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      HSIZE_BYTE: strb = 4'b0001 << addr_lo;
      HSIZE_HALF: strb = 4'b0011 << {addr_lo[1], 1'b0};
      default:    strb = 4'hF;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Counts ACCESS cycles spent waiting on pready; expired is asserted during the
// TIMEOUT-th consecutive waiting cycle. TIMEOUT=0 never expires.
module apb_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)    cnt_d = '0;
    else if (run) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      assign expired = run && (cnt_q == CW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/ahb2apb_nport.sv
// AHB-Lite slave bridging single transfers onto NSLV APB slaves selected by an
// address field. Every AHB/APB output except pwdata is registered.
module ahb2apb_nport
  import ahb2apb_nport_pkg::*;
#(
  parameter int ADDR    = 24,
  parameter int NSLV    = 4,
  parameter int SLV_LSB = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              hsel,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hsize,
  input  logic [3:0]        hprot,
  input  logic [ADDR-1:0]   haddr,
  input  logic              hwrite,
  input  logic [31:0]       hwdata,
  input  logic              hready,
  output logic [31:0]       hrdata,
  output logic              hresp,
  output logic              hreadyout,
  output logic [NSLV-1:0]   psel,
  output logic              penable,
  output logic [2:0]        pprot,
  output logic [ADDR-1:0]   paddr,
  output logic              pwrite,
  output logic [31:0]       pwdata,
  output logic [3:0]        pstrb,
  input  logic [NSLV*32-1:0] prdata,
  input  logic [NSLV-1:0]   pready,
  input  logic [NSLV-1:0]   pslverr,
  output logic              timeout_o
);

  localparam int IDXW = (NSLV > 1) ? $clog2(NSLV) : 1;

  // Handshake: an AHB transfer is taken when hsel & hready & htrans[NONSEQ|SEQ];
  // an APB access completes on the edge where psel & penable & pready[idx].
  state_e          state_q, state_d;
  logic            hreadyout_q, hreadyout_d;
  logic            hresp_q, hresp_d;
  logic [31:0]     hrdata_q, hrdata_d;
  logic [NSLV-1:0] psel_q, psel_d;
  logic            penable_q, penable_d;
  logic [ADDR-1:0] paddr_q, paddr_d;
  logic            pwrite_q, pwrite_d;
  logic [3:0]      pstrb_q, pstrb_d;
  logic [2:0]      pprot_q, pprot_d;
  logic            timeout_q, timeout_d;

  logic [3:0]      idx;
  logic            accept, addr_ok, size_ok;
  logic [NSLV-1:0] sel_onehot;
  logic            sel_ready, sel_err, expired;
  logic [31:0]     sel_rdata;
  logic            unused_hprot;

  generate
    if (NSLV == 1) begin : g_one
      assign idx = 4'd0;
    end else begin : g_many
      assign idx = 4'(haddr[SLV_LSB +: IDXW]);
    end
  endgenerate

  assign accept       = hsel && hready &&
                        (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
  assign addr_ok      = idx < 4'(NSLV);
  assign size_ok      = hsize <= HSIZE_WORD;
  assign sel_onehot   = NSLV'(1) << idx;
  assign unused_hprot = &{1'b0, hprot[3:2]};

  // psel_q is one-hot during ACCESS, so masking picks out the addressed slave.
  assign sel_ready = |(pready & psel_q);
  assign sel_err   = |(pslverr & psel_q);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (psel_q[i]) sel_rdata = prdata[i*32 +: 32];
    end
  end

  apb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_q == ST_SETUP),
    .run     ((state_q == ST_ACCESS) && !sel_ready),
    .expired (expired)
  );

  always_comb begin
    state_d     = state_q;
    hreadyout_d = hreadyout_q;
    hresp_d     = hresp_q;
    hrdata_d    = hrdata_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pstrb_d     = pstrb_q;
    pprot_d     = pprot_q;
    timeout_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        hreadyout_d = 1'b1;
        hresp_d     = 1'b0;
        if (accept) begin
          hreadyout_d = 1'b0;
          if (addr_ok && size_ok) begin
            state_d  = ST_SETUP;
            psel_d   = sel_onehot;
            paddr_d  = haddr;
            pwrite_d = hwrite;
            pstrb_d  = hwrite ? strb_for(hsize, haddr[1:0]) : 4'h0;
            pprot_d  = {~hprot[0], 1'b0, hprot[1]};
          end else begin
            state_d = ST_ERR1;
            hresp_d = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (sel_ready) begin
          psel_d    = '0;
          penable_d = 1'b0;
          if (sel_err) begin
            state_d = ST_ERR1;
            hresp_d = 1'b1;
          end else begin
            state_d     = ST_IDLE;
            hreadyout_d = 1'b1;
            hrdata_d    = sel_rdata;
          end
        end else if (expired) begin
          psel_d    = '0;
          penable_d = 1'b0;
          timeout_d = 1'b1;
          state_d   = ST_ERR1;
          hresp_d   = 1'b1;
        end
      end
      ST_ERR1: begin
        state_d     = ST_ERR2;
        hreadyout_d = 1'b1;
        hresp_d     = 1'b1;
      end
      ST_ERR2: begin
        // A transfer presented here is the one the master cancels; drop it.
        state_d     = ST_IDLE;
        hreadyout_d = 1'b1;
        hresp_d     = 1'b0;
      end
      default: begin
        state_d     = ST_IDLE;
        hreadyout_d = 1'b1;
        hresp_d     = 1'b0;
        psel_d      = '0;
        penable_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pstrb_q     <= pstrb_d;
      pprot_q     <= pprot_d;
      timeout_q   <= timeout_d;
    end
  end

  assign hrdata    = hrdata_q;
  assign hresp     = hresp_q;
  assign hreadyout = hreadyout_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pstrb     = pstrb_q;
  assign pprot     = pprot_q;
  assign timeout_o = timeout_q;
  assign pwdata    = hwdata;

endmodule

// File: tb/tb_ahb2apb_nport.sv
// Bench for ahb2apb_nport: instance A (NSLV=4, TIMEOUT=4) and instance B
// (NSLV=3, TIMEOUT=0) share the AHB bus; use_b picks the one being addressed.
module tb_ahb2apb_nport;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        use_b = 1'b0;
  logic        hsel = 1'b0, hwrite = 1'b0;
  logic [1:0]  htrans = 2'b00;
  logic [2:0]  hsize = 3'd0;
  logic [3:0]  hprot = 4'd0;
  logic [23:0] haddr = 24'd0;
  logic [31:0] hwdata = 32'd0;
  logic        hready;
  logic [3:0]  pr_rdy = 4'd0, pr_err = 4'd0;
  logic [31:0] pd [4];
  logic [127:0] prdata_a;
  logic [95:0]  prdata_b;

  logic [31:0] hrdata_a, hrdata_b, pwdata_a, pwdata_b;
  logic        hresp_a, hresp_b, hreadyout_a, hreadyout_b;
  logic [3:0]  psel_a;
  logic [2:0]  psel_b;
  logic        penable_a, penable_b, pwrite_a, pwrite_b, timeout_a, timeout_b;
  logic [2:0]  pprot_a, pprot_b;
  logic [23:0] paddr_a, paddr_b;
  logic [3:0]  pstrb_a, pstrb_b;

  assign prdata_a = {pd[3], pd[2], pd[1], pd[0]};
  assign prdata_b = {pd[2], pd[1], pd[0]};
  assign hready   = use_b ? hreadyout_b : hreadyout_a;

  logic [31:0] o_hrdata, o_pwdata;
  logic        o_hresp, o_hreadyout, o_penable, o_pwrite, o_timeout;
  logic [3:0]  o_psel, o_pstrb;
  logic [2:0]  o_pprot;
  logic [23:0] o_paddr;
  assign o_hrdata    = use_b ? hrdata_b : hrdata_a;
  assign o_pwdata    = use_b ? pwdata_b : pwdata_a;
  assign o_hresp     = use_b ? hresp_b : hresp_a;
  assign o_hreadyout = use_b ? hreadyout_b : hreadyout_a;
  assign o_penable   = use_b ? penable_b : penable_a;
  assign o_pwrite    = use_b ? pwrite_b : pwrite_a;
  assign o_timeout   = use_b ? timeout_b : timeout_a;
  assign o_psel      = use_b ? {1'b0, psel_b} : psel_a;
  assign o_pstrb     = use_b ? pstrb_b : pstrb_a;
  assign o_pprot     = use_b ? pprot_b : pprot_a;
  assign o_paddr     = use_b ? paddr_b : paddr_a;

  ahb2apb_nport #(.ADDR(24), .NSLV(4), .SLV_LSB(16), .TIMEOUT(4)) u_a (
    .clk(clk), .reset_n(reset_n), .hsel(hsel && !use_b), .htrans(htrans),
    .hsize(hsize), .hprot(hprot), .haddr(haddr), .hwrite(hwrite),
    .hwdata(hwdata), .hready(hready), .hrdata(hrdata_a), .hresp(hresp_a),
    .hreadyout(hreadyout_a), .psel(psel_a), .penable(penable_a),
    .pprot(pprot_a), .paddr(paddr_a), .pwrite(pwrite_a), .pwdata(pwdata_a),
    .pstrb(pstrb_a), .prdata(prdata_a), .pready(pr_rdy), .pslverr(pr_err),
    .timeout_o(timeout_a)
  );

  ahb2apb_nport #(.ADDR(24), .NSLV(3), .SLV_LSB(16), .TIMEOUT(0)) u_b (
    .clk(clk), .reset_n(reset_n), .hsel(hsel && use_b), .htrans(htrans),
    .hsize(hsize), .hprot(hprot), .haddr(haddr), .hwrite(hwrite),
    .hwdata(hwdata), .hready(hready), .hrdata(hrdata_b), .hresp(hresp_b),
    .hreadyout(hreadyout_b), .psel(psel_b), .penable(penable_b),
    .pprot(pprot_b), .paddr(paddr_b), .pwrite(pwrite_b), .pwdata(pwdata_b),
    .pstrb(pstrb_b), .prdata(prdata_b), .pready(pr_rdy[2:0]),
    .pslverr(pr_err[2:0]), .timeout_o(timeout_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         waits;
    logic       resp;
    int         pcyc;
    int         tmo;
    logic [3:0] pstrb;
    logic [2:0] pprot;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic        bsel;
    logic [23:0] addr;
    logic        wr;
    logic [2:0]  sz;
    logic [3:0]  prot;
    logic [31:0] wd;
    int          low;
    logic        err;
    logic [31:0] rd;
    exp_t        e;
  } vec_t;

  // Reference: outcome of one transfer from the bridge's rules, in cycle counts.
  function automatic exp_t model(input logic bsel, input logic [23:0] addr, input logic wr,
                                 input logic [2:0] sz, input logic [3:0] prot, input int low,
                                 input logic err, input logic [31:0] rd);
    exp_t e;
    int nslv, tmo, idx, nb, base;
    nslv = bsel ? 3 : 4;
    tmo  = bsel ? 0 : 4;
    idx  = int'(addr[17:16]);
    e = '{0, 1'b0, 0, 0, 4'h0, 3'b000, rd};
    e.pprot = {~prot[0], 1'b0, prot[1]};
    if (wr && sz <= 3'd2) begin
      nb   = 1 << sz;
      base = (int'(addr[1:0]) / nb) * nb;
      for (int b = 0; b < 4; b++) e.pstrb[b] = (b >= base) && (b < base + nb);
    end
    if (idx >= nslv || sz > 3'd2) begin
      e.waits = 1; e.resp = 1'b1;
    end else if (tmo > 0 && low >= tmo) begin
      e.waits = tmo + 2; e.resp = 1'b1; e.pcyc = tmo + 1; e.tmo = 1;
    end else begin
      e.pcyc = low + 2; e.waits = low + 2 + int'(err); e.resp = err;
    end
    return e;
  endfunction

  // ---------------- driver ----------------
  int          r_waits, r_pcyc, r_tmo, r_bad;
  logic        r_resp, r_resp_prev, r_done;
  logic [3:0]  r_pstrb;
  logic [2:0]  r_pprot;
  logic [31:0] r_rdata;

  task automatic idle_bus();
    hsel = 1'b0; htrans = 2'b00;
  endtask

  task automatic run_xfer(input vec_t v);
    int k, t;
    logic [3:0] exp_sel;
    t = int'(v.addr[17:16]);
    exp_sel = 4'b0001 << v.addr[17:16];
    use_b = v.bsel;
    @(negedge clk);
    hsel = 1'b1; htrans = 2'b10; haddr = v.addr; hwrite = v.wr;
    hsize = v.sz; hprot = v.prot; hwdata = $urandom;
    @(negedge clk);
    idle_bus(); haddr = 24'($urandom); hwdata = v.wd;
    r_waits = 0; r_pcyc = 0; r_tmo = 0; r_bad = 0; k = 0;
    r_resp = 1'b0; r_resp_prev = 1'b0; r_done = 1'b0;
    r_pstrb = 4'h0; r_pprot = 3'b000; r_rdata = 32'h0;
    for (int n = 0; n < 400 && !r_done; n++) begin
      if (o_timeout) r_tmo++;
      if (o_psel != 4'h0) begin
        r_pcyc++;
        if (o_psel != exp_sel || o_penable != (r_pcyc > 1) || o_paddr != v.addr ||
            o_pwrite != v.wr || o_pwdata != v.wd) r_bad++;
        r_pstrb = o_pstrb; r_pprot = o_pprot;
      end else if (o_penable) r_bad++;
      if (o_hreadyout) begin
        r_done = 1'b1; r_resp = o_hresp; r_rdata = o_hrdata;
      end else begin
        r_waits++; r_resp_prev = o_hresp;
        pr_rdy = 4'($urandom); pr_err = 4'($urandom);
        for (int i = 0; i < 4; i++) pd[i] = $urandom;
        if (o_psel != 4'h0 && o_penable) begin
          k++;
          pr_rdy[t] = (k > v.low);
          pr_err[t] = v.err && (k > v.low);
          pd[t]     = v.rd;
        end
        @(negedge clk);
      end
    end
    pr_rdy = 4'h0; pr_err = 4'h0;
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    run_xfer(v);
    check($sformatf("%s.done", tag), 32'(r_done), 32'd1);
    check($sformatf("%s.waits", tag), 32'(r_waits), 32'(v.e.waits));
    check($sformatf("%s.hresp", tag), 32'(r_resp), 32'(v.e.resp));
    check($sformatf("%s.hresp_prev", tag), 32'(r_resp_prev), 32'(v.e.resp));
    check($sformatf("%s.psel_cycles", tag), 32'(r_pcyc), 32'(v.e.pcyc));
    check($sformatf("%s.timeouts", tag), 32'(r_tmo), 32'(v.e.tmo));
    check($sformatf("%s.apb_bad", tag), 32'(r_bad), 32'd0);
    if (v.e.pcyc > 0) begin
      check($sformatf("%s.pstrb", tag), 32'(r_pstrb), 32'(v.e.pstrb));
      check($sformatf("%s.pprot", tag), 32'(r_pprot), 32'(v.e.pprot));
    end
    if (!v.wr && !v.e.resp) check($sformatf("%s.hrdata", tag), r_rdata, v.e.rdata);
  endtask

  // ---------------- test ----------------
  vec_t tbl [11];
  vec_t v;

  initial begin
    for (int i = 0; i < 4; i++) pd[i] = 32'h0;
    tbl[0]  = '{1'b0, 24'h020010, 1'b1, 3'd2, 4'b0011, 32'hDEADBEEF, 0,  1'b0, 32'h0,
                '{2, 1'b0, 2, 0, 4'hF, 3'b001, 32'h0}};
    tbl[1]  = '{1'b0, 24'h010003, 1'b0, 3'd0, 4'b0001, 32'h0, 3, 1'b0, 32'h11223344,
                '{5, 1'b0, 5, 0, 4'h0, 3'b000, 32'h11223344}};
    tbl[2]  = '{1'b0, 24'h000000, 1'b1, 3'd2, 4'b0001, 32'h5A5A5A5A, 0, 1'b1, 32'h0,
                '{3, 1'b1, 2, 0, 4'hF, 3'b000, 32'h0}};
    tbl[3]  = '{1'b0, 24'h010000, 1'b0, 3'd2, 4'b0010, 32'h0, 20, 1'b0, 32'h0,
                '{6, 1'b1, 5, 1, 4'h0, 3'b101, 32'h0}};
    tbl[4]  = '{1'b1, 24'h030000, 1'b1, 3'd2, 4'b0001, 32'h12345678, 0, 1'b0, 32'h0,
                '{1, 1'b1, 0, 0, 4'h0, 3'b000, 32'h0}};
    tbl[5]  = '{1'b0, 24'h020000, 1'b1, 3'd3, 4'b0001, 32'h87654321, 0, 1'b0, 32'h0,
                '{1, 1'b1, 0, 0, 4'h0, 3'b000, 32'h0}};
    tbl[6]  = '{1'b1, 24'h020000, 1'b0, 3'd2, 4'b0000, 32'h0, 10, 1'b0, 32'hCAFEF00D,
                '{12, 1'b0, 12, 0, 4'h0, 3'b100, 32'hCAFEF00D}};
    tbl[7]  = '{1'b0, 24'h030002, 1'b1, 3'd1, 4'b0001, 32'hA5A50000, 0, 1'b0, 32'h0,
                '{2, 1'b0, 2, 0, 4'hC, 3'b000, 32'h0}};
    tbl[8]  = '{1'b0, 24'h000001, 1'b1, 3'd0, 4'b0001, 32'h0000EE00, 1, 1'b0, 32'h0,
                '{3, 1'b0, 3, 0, 4'h2, 3'b000, 32'h0}};
    tbl[9]  = '{1'b0, 24'h010006, 1'b1, 3'd1, 4'b0001, 32'hBEEF0000, 2, 1'b1, 32'h0,
                '{5, 1'b1, 4, 0, 4'hC, 3'b000, 32'h0}};
    tbl[10] = '{1'b1, 24'h020003, 1'b1, 3'd0, 4'b0001, 32'h77000000, 0, 1'b1, 32'h0,
                '{3, 1'b1, 2, 0, 4'h8, 3'b000, 32'h0}};

    // Reset values
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.hreadyout", 32'(hreadyout_a), 32'd1);
    check("rst.hresp", 32'(hresp_a), 32'd0);
    check("rst.hrdata", hrdata_a, 32'd0);
    check("rst.psel", 32'(psel_a), 32'd0);
    check("rst.penable", 32'(penable_a), 32'd0);
    check("rst.paddr", 32'(paddr_a), 32'd0);
    check("rst.pwrite_pstrb_pprot", {24'd0, pwrite_a, pstrb_a, pprot_a}, 32'd0);
    check("rst.timeout", 32'(timeout_a), 32'd0);
    check("rst.b_psel_ready", {28'd0, psel_b, hreadyout_b}, 32'd1);
    reset_n = 1'b1;

    // IDLE and BUSY get zero-wait OKAY with no APB activity
    @(negedge clk);
    hsel = 1'b1; htrans = 2'b01; haddr = 24'h010000; hwrite = 1'b1; hsize = 3'd2;
    @(negedge clk);
    check("busy.hreadyout", 32'(o_hreadyout), 32'd1);
    check("busy.hresp", 32'(o_hresp), 32'd0);
    check("busy.psel", 32'(o_psel), 32'd0);
    htrans = 2'b00;
    @(negedge clk);
    check("idle.hreadyout", 32'(o_hreadyout), 32'd1);
    check("idle.psel", 32'(o_psel), 32'd0);
    idle_bus();

    for (int i = 0; i < 11; i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

    // A transfer offered during ERR2 is cancelled
    use_b = 1'b0;
    @(negedge clk);
    hsel = 1'b1; htrans = 2'b10; hsize = 3'd3; haddr = 24'h000000; hwrite = 1'b1;
    @(negedge clk);
    idle_bus();
    check("err2.e1_hresp", 32'(o_hresp), 32'd1);
    check("err2.e1_hreadyout", 32'(o_hreadyout), 32'd0);
    @(negedge clk);
    check("err2.e2_hresp", 32'(o_hresp), 32'd1);
    check("err2.e2_hreadyout", 32'(o_hreadyout), 32'd1);
    hsel = 1'b1; htrans = 2'b10; hsize = 3'd2; haddr = 24'h010000;
    @(negedge clk);
    idle_bus();
    check("err2.cancel_psel", 32'(o_psel), 32'd0);
    check("err2.after_ready_resp", {30'd0, o_hreadyout, o_hresp}, 32'd2);
    @(negedge clk);
    check("err2.cancel_psel2", 32'(o_psel), 32'd0);

    // Randomized transfers against the reference
    for (int i = 0; i < 40; i++) begin
      v.bsel = (i >= 30);
      v.addr = 24'($urandom);
      v.wr   = 1'($urandom);
      v.sz   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      v.prot = 4'($urandom);
      v.wd   = $urandom;
      v.low  = $urandom_range(0, 6);
      v.err  = ($urandom_range(0, 3) == 0);
      v.rd   = $urandom;
      v.e    = model(v.bsel, v.addr, v.wr, v.sz, v.prot, v.low, v.err, v.rd);
      apply_vec(v, $sformatf("rnd%0d", i));
    end

    // Reset during ACCESS abandons the transfer silently
    use_b = 1'b0; pr_rdy = 4'h0; pr_err = 4'h0;
    @(negedge clk);
    hsel = 1'b1; htrans = 2'b10; haddr = 24'h010004; hwrite = 1'b1; hsize = 3'd2; hprot = 4'b0001;
    @(negedge clk);
    idle_bus();
    check("rstacc.setup_psel", 32'(o_psel), 32'h2);
    check("rstacc.setup_penable", 32'(o_penable), 32'd0);
    @(negedge clk);
    check("rstacc.access_penable", 32'(o_penable), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("rstacc.psel", 32'(o_psel), 32'd0);
    check("rstacc.penable", 32'(o_penable), 32'd0);
    check("rstacc.hreadyout", 32'(o_hreadyout), 32'd1);
    check("rstacc.hresp", 32'(o_hresp), 32'd0);
    check("rstacc.paddr", 32'(o_paddr), 32'd0);
    check("rstacc.timeout", 32'(o_timeout), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
